// File: rtl/flp_pkg.sv
// flp_pkg: shared field widths, class codes and loader states for the operand loader
package flp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [2:0] CLS_NORMAL = 3'd0;
  localparam logic [2:0] CLS_ZERO = 3'd1;
  localparam logic [2:0] CLS_DENORM = 3'd2;
  localparam logic [2:0] CLS_INF = 3'd3;
  localparam logic [2:0] CLS_NAN = 3'd4;
  typedef enum logic [1:0] {S_A, S_B, S_OUT} state_t;
endpackage

// File: rtl/flp_classify.sv
// flp_classify: IEEE-754 single class from exponent/fraction (sign bit not needed, so only the magnitude enters)
module flp_classify
  import flp_pkg::*;
(
  input  logic [EXP_W+FRAC_W-1:0] mag,
  output logic [2:0]              cls
);
  logic [EXP_W-1:0] e;
  logic fz;
  // decode exponent extremes and fraction-zero into a class code
  always_comb begin
    e = mag[FRAC_W +: EXP_W];
    fz = mag[FRAC_W-1:0] == '0;
    cls = e == '0 ? (fz ? CLS_ZERO : CLS_DENORM) : e == EXP_MAX ? (fz ? CLS_INF : CLS_NAN) : CLS_NORMAL;
  end
endmodule

// File: rtl/flp_operand_loader.sv
// flp_operand_loader: assembles two float operands from a byte stream and holds them for the adder; FLP_SWAP_EN puts the larger magnitude on flp_a
module flp_operand_loader
  import flp_pkg::*;
#(
  parameter int BUS_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [BUS_W-1:0]  in_data,
  output logic              in_ready,
  output logic [WORD_W-1:0] flp_a,
  output logic [WORD_W-1:0] flp_b,
  output logic [2:0]        a_class,
  output logic [2:0]        b_class,
  output logic              swapped,
  output logic              ops_valid,
  input  logic              ops_ready
);
  localparam int BEATS = WORD_W / BUS_W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WORD_W-1:0] a_sh, b_word, ld_a, ld_b;
  logic [WORD_W-BUS_W-1:0] b_sh;
  logic acc, last, swp;
  logic [2:0] ca, cb;
  assign in_ready = rst_n && !flush && state != S_OUT;
  assign ops_valid = state == S_OUT;
  assign acc = in_valid && in_ready;
  assign last = cnt == CW'(BEATS - 1);
  assign b_word = {b_sh, in_data};
`ifdef FLP_SWAP_EN
  assign swp = b_word[WORD_W-2:0] > a_sh[WORD_W-2:0];
`else
  assign swp = 1'b0;
`endif
  assign ld_a = swp ? b_word : a_sh;
  assign ld_b = swp ? a_sh : b_word;
  flp_classify u_cls_a (.mag(ld_a[WORD_W-2:0]), .cls(ca));
  flp_classify u_cls_b (.mag(ld_b[WORD_W-2:0]), .cls(cb));
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_A;
    else state <= nxt;
  end
  // next state: flush aborts everywhere, words advance on their last beat, pair leaves on handshake
  always_comb begin
    nxt = state;
    nxt = flush ? S_A :
          state == S_A ? (acc && last ? S_B : S_A) :
          state == S_B ? (acc && last ? S_OUT : S_B) :
          (ops_ready ? S_A : S_OUT);
  end
  // beat counter, shift registers and held operand pair
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      flp_a <= '0;
      flp_b <= '0;
      a_class <= CLS_ZERO;
      b_class <= CLS_ZERO;
      swapped <= 1'b0;
    end else if (acc) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (state == S_A) a_sh <= {a_sh[WORD_W-BUS_W-1:0], in_data};
      else b_sh <= b_word[WORD_W-BUS_W-1:0];
      if (state == S_B && last) begin
        flp_a <= ld_a;
        flp_b <= ld_b;
        a_class <= ca;
        b_class <= cb;
        swapped <= swp;
      end
    end
  end
endmodule

// File: tb/tb_flp_operand_loader.sv
// tb_flp_operand_loader: scoreboard bench for the operand loader; FLP_SWAP_EN selects the swapping reference
module tb_flp_operand_loader;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, ops_ready = 1;
  logic [7:0] in_data = 0;
  logic in_ready, swapped, ops_valid;
  logic [31:0] flp_a, flp_b;
  logic [2:0] a_class, b_class;

  flp_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flp_a(flp_a), .flp_b(flp_b), .a_class(a_class), .b_class(b_class),
    .swapped(swapped), .ops_valid(ops_valid), .ops_ready(ops_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        sw;
  } pair_t;

  pair_t q[$];
  pair_t cur, act, p;
  logic [7:0] bq[$];
  logic [31:0] wa, wb;
  int errors = 0, checks = 0, hold_cnt = 0;
  bit held = 0, took = 0, zeroed = 1, prev_v = 0, rdy_rand = 0, gaps = 0;

  function automatic logic [2:0] cls_of(logic [31:0] w);
    if (w[30:23] == 8'd0) return w[22:0] == 0 ? 3'd1 : 3'd2;
    if (w[30:23] == 8'd255) return w[22:0] == 0 ? 3'd3 : 3'd4;
    return 3'd0;
  endfunction

  task automatic chk(input string n, input logic [70:0] a, input logic [70:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // reference model: collects accepted bytes, emits the expected pair after eight
  always @(posedge clk) begin
    took = 0;
    if (!rst_n || flush) begin
      bq.delete();
      held = 0;
      zeroed = 1;
    end else if (held) begin
      if (ops_ready) held = 0;
    end else if (in_valid) begin
      took = 1;
      bq.push_back(in_data);
      if (bq.size() == 8) begin
        wa = {bq[0], bq[1], bq[2], bq[3]};
        wb = {bq[4], bq[5], bq[6], bq[7]};
        p.sw = 0;
`ifdef FLP_SWAP_EN
        if (wb[30:0] > wa[30:0]) p.sw = 1;
`endif
        p.a = p.sw ? wb : wa;
        p.b = p.sw ? wa : wb;
        p.ca = cls_of(p.a);
        p.cb = cls_of(p.b);
        q.push_back(p);
        held = 1;
        zeroed = 0;
        bq.delete();
      end
    end
  end

  // monitor: handshake signals every cycle, pair on arrival, stability while held
  always @(negedge clk) begin
    act = {flp_a, flp_b, a_class, b_class, swapped};
    chk("in_ready", 71'(in_ready), 71'(rst_n && !flush && !held));
    chk("ops_valid", 71'(ops_valid), 71'(held));
    if (ops_valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair actual=%h required=none", act);
      end else begin
        cur = q.pop_front();
        chk("pair", act, cur);
      end
    end else if (ops_valid) chk("held_stable", act, cur);
    if (zeroed) chk("zero_state", act, {32'd0, 32'd0, 3'd1, 3'd1, 1'b0});
    prev_v = ops_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
    ops_ready = (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1) && hold_cnt == 0;
    if (held && hold_cnt > 0) hold_cnt--;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) begin
      in_valid = 0;
      repeat ($urandom_range(0, 3)) step();
    end
    in_valid = 1;
    in_data = b;
    do begin
      step();
      n++;
    end while (!took && n < 300);
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL byte_timeout actual=stalled required=accepted data=%h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    send_word(a);
    send_word(b);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] rw();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 4))
      0: w[30:23] = 8'd0;
      1: w[30:23] = 8'd255;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) w[22:0] = 0;
    return w;
  endfunction

  initial begin
    repeat (3) step();
    rst_n = 1;
    send_pair(32'h41400000, 32'h420C0000);
    idle(2);
    hold_cnt = 5;
    send_pair(32'h41400000, 32'h420C0000);
    send_byte(8'h7F);
    gaps = 1;
    send_byte(8'hC0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h00000001);
    gaps = 0;
    idle(2);
    send_pair(32'h7F800000, 32'h80000000);
    idle(2);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    in_valid = 1;
    in_data = 8'hEE;
    flush = 1;
    step();
    flush = 0;
    send_pair(32'h408C0000, 32'h41D40000);
    idle(2);
    hold_cnt = 1000;
    send_pair(32'hC0000000, 32'h3F800000);
    in_valid = 0;
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    hold_cnt = 0;
    idle(2);
    send_word(32'h3F800000);
    send_byte(8'h40);
    send_byte(8'h00);
    in_valid = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    send_pair(32'h3F800000, 32'h40000000);
    idle(2);
    rdy_rand = 1;
    gaps = 1;
    repeat (25) send_pair(rw(), rw());
    gaps = 0;
    rdy_rand = 0;
    idle(10);
    chk("queue_drained", 71'(q.size()), 71'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
